// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the parity-protected adder pipeline and its flow scheduler.
package adder_pipe_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        SCRUB = 1'b1
    } sched_state_e;

    localparam int DEFAULT_WORD_WIDTH = 8;
    localparam int DEFAULT_LAYERS     = 4;

endpackage

// File: rtl/adder_pipe_scheduler.sv
// Flow controller for the cascaded adder pipeline: handshakes, per-layer hold,
// error qualification, post-error scrub and sticky alarm / saturating error count.
module adder_pipe_scheduler
    import adder_pipe_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int LAYERS     = DEFAULT_LAYERS,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic [WORD_WIDTH-1:0] input_vector,
    output logic [LAYERS-1:0]     hold_signals,
    input  logic [LAYERS-1:0]     error_signals,
    input  logic [WORD_WIDTH-1:0] sum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  alarm,
    input  logic                  alarm_clr,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  busy
);

    localparam int L   = LAYERS - 1;
    localparam int SCW = $clog2(LAYERS + 1);
    localparam logic [SCW-1:0] SCRUB_LAST = SCW'(LAYERS - 1);

    sched_state_e         state_q, state_d;
    logic [LAYERS-1:0]    vld_q, vld_d;
    logic [LAYERS-1:0]    hold_s;
    logic [SCW-1:0]       scrub_cnt_q, scrub_cnt_d;
    logic                 alarm_q, alarm_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                 err_hit_s;
    logic                 accept_s;

    assign err_hit_s    = (state_q == RUN) & (|(error_signals & vld_q));
    assign accept_s     = in_valid & in_ready;
    assign input_vector = in_data;
    assign out_data     = sum;
    assign alarm        = alarm_q;
    assign err_count    = err_cnt_q;

    // A layer holds only when it and every layer after it are live and the sink stalls,
    // which is the unrolled form of hold[i] = vld[i] & hold[i+1].
    for (genvar i = 0; i < LAYERS; i++) begin : g_layer
        assign hold_s[i] = (&vld_q[L:i]) & ~out_ready;
        if (i == 0) begin : g_first
            assign vld_d[i] = err_hit_s ? 1'b0 : (hold_s[i] ? vld_q[i] : accept_s);
        end else begin : g_adv
            assign vld_d[i] = err_hit_s ? 1'b0 : (hold_s[i] ? vld_q[i] : vld_q[i-1]);
        end
    end

    // State, occupancy, scrub counter, alarm and error counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            vld_q       <= '0;
            scrub_cnt_q <= '0;
            alarm_q     <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            scrub_cnt_q <= scrub_cnt_d;
            alarm_q     <= alarm_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Next state: a qualified error starts a scrub lasting exactly LAYERS cycles
    always_comb begin
        state_d     = state_q;
        scrub_cnt_d = scrub_cnt_q;
        case (state_q)
            RUN: begin
                scrub_cnt_d = '0;
                if (err_hit_s) begin
                    state_d = SCRUB;
                end else begin
                    state_d = RUN;
                end
            end
            SCRUB: begin
                if (scrub_cnt_q == SCRUB_LAST) begin
                    state_d     = RUN;
                    scrub_cnt_d = '0;
                end else begin
                    state_d     = SCRUB;
                    scrub_cnt_d = scrub_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = RUN;
                scrub_cnt_d = '0;
            end
        endcase
    end

    // Sticky alarm (set beats clear) and saturating error count
    always_comb begin
        alarm_d   = alarm_q;
        err_cnt_d = err_cnt_q;
        if (err_hit_s) begin
            alarm_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else if (alarm_clr) begin
            alarm_d = 1'b0;
        end else begin
            alarm_d = alarm_q;
        end
    end

    // Outputs: in_ready also drops on a qualified error so no word is claimed and then discarded
    always_comb begin
        hold_signals = '0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (state_q)
            RUN: begin
                hold_signals = hold_s;
                in_ready     = ~hold_s[0] & ~err_hit_s;
                out_valid    = vld_q[L] & ~err_hit_s;
                busy         = 1'b0;
            end
            SCRUB: begin
                hold_signals = '0;
                in_ready     = 1'b0;
                out_valid    = 1'b0;
                busy         = 1'b1;
            end
            default: begin
                hold_signals = '0;
                in_ready     = 1'b0;
                out_valid    = 1'b0;
                busy         = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_adder_pipe_scheduler.sv
// Directed self-checking bench for adder_pipe_scheduler with a stand-in adder pipeline
// where every layer adds one, so a word w leaves the last layer as w + 4.
module tb_adder_pipe_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic [3:0] error_signals;
    logic       out_ready;
    logic       alarm_clr;
    logic [7:0] sum;

    logic       in_ready, out_valid, alarm, busy;
    logic [7:0] input_vector, out_data, err_count;
    logic [3:0] hold_signals;

    logic       in_ready_c, out_valid_c, alarm_c, busy_c;
    logic [7:0] input_vector_c, out_data_c;
    logic [3:0] hold_signals_c;
    logic [1:0] err_count_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder_pipe_scheduler #(.WORD_WIDTH(8), .LAYERS(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .input_vector(input_vector), .hold_signals(hold_signals), .error_signals(error_signals),
        .sum(sum), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .alarm(alarm), .alarm_clr(alarm_clr), .err_count(err_count), .busy(busy)
    );

    adder_pipe_scheduler #(.WORD_WIDTH(8), .LAYERS(4), .CNT_WIDTH(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
        .input_vector(input_vector_c), .hold_signals(hold_signals_c), .error_signals(error_signals),
        .sum(sum), .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
        .alarm(alarm_c), .alarm_clr(alarm_clr), .err_count(err_count_c), .busy(busy_c)
    );

    logic [7:0] pipe_q [4];

    always_ff @(posedge clk) begin
        if (!hold_signals[0]) pipe_q[0] <= input_vector + 8'd1;
        for (int i = 1; i < 4; i++) begin
            if (!hold_signals[i]) pipe_q[i] <= pipe_q[i-1] + 8'd1;
        end
    end
    assign sum = pipe_q[3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    localparam logic [7:0]  T1_VLD  = 8'b0111_0000;
    localparam logic [11:0] T2_VLD  = 12'b0111_1111_0000;
    localparam logic [12:0] T3_VLD  = 13'b0_1111_1111_0000;
    localparam logic [12:0] T3_RDY  = 13'b1_1111_0111_1111;
    localparam logic [14:0] T4_VLD  = 15'b010_0000_0000_0000;

    logic [7:0] t1_dat [8]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h06, 8'h07, 8'h00};
    logic [7:0] t2_dat [12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h14, 8'h14, 8'h14, 8'h14,
                                8'h15, 8'h16, 8'h17, 8'h00};
    logic [7:0] t3_dat [13] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h24, 8'h24, 8'h24, 8'h24,
                                8'h24, 8'h34, 8'h35, 8'h36, 8'h00};
    logic [3:0] t3_hold [13] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'hF,
                                 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [7:0] t6_cnt  [5] = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    logic [1:0] t6_cntc [5] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; error_signals = 4'h0;
        out_ready = 1'b1; alarm_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_hold", hold_signals, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_alarm", alarm, 0);
        check_eq("rst_err_count", err_count, 0);
        adv();
        rst = 1'b0;

        // Streaming three words
        for (int k = 0; k < 8; k++) begin
            in_valid = (k < 3); in_data = 8'(k + 1);
            @(negedge clk);
            check_eq("t1_in_ready", in_ready, 1);
            check_eq("t1_out_valid", out_valid, T1_VLD[k]);
            if (T1_VLD[k]) check_eq("t1_out_data", out_data, t1_dat[k]);
            adv();
        end

        // Backpressure on a full pipeline
        for (int k = 0; k < 12; k++) begin
            in_valid = (k < 4); in_data = 8'(16 + k);
            out_ready = !(k >= 4 && k <= 6);
            @(negedge clk);
            if (k >= 4 && k <= 6) begin
                check_eq("t2_hold_stall", hold_signals, 4'hF);
                check_eq("t2_in_ready_stall", in_ready, 0);
            end
            check_eq("t2_out_valid", out_valid, T2_VLD[k]);
            if (T2_VLD[k]) check_eq("t2_out_data", out_data, t2_dat[k]);
            adv();
        end

        // Bubble collapse
        for (int k = 0; k < 13; k++) begin
            in_valid = (k == 0) || (k >= 4 && k <= 7);
            in_data  = (k == 0) ? 8'h20 : 8'(48 + k - 4);
            out_ready = !(k >= 3 && k <= 7);
            @(negedge clk);
            check_eq("t3_hold", hold_signals, t3_hold[k]);
            check_eq("t3_in_ready", in_ready, T3_RDY[k]);
            check_eq("t3_out_valid", out_valid, T3_VLD[k]);
            if (T3_VLD[k]) check_eq("t3_out_data", out_data, t3_dat[k]);
            adv();
        end

        // Error in a live layer, flush and scrub
        for (int k = 0; k < 15; k++) begin
            in_valid = (k <= 1) || (k >= 4 && k <= 9);
            in_data  = (k == 0) ? 8'h40 : ((k == 1) ? 8'h41 : 8'h50);
            error_signals = (k == 4) ? 4'b0100 : 4'b0000;
            out_ready = !(k >= 5 && k <= 8);
            @(negedge clk);
            check_eq("t4_out_valid", out_valid, T4_VLD[k]);
            if (T4_VLD[k]) check_eq("t4_out_data", out_data, 8'h54);
            if (k >= 5 && k <= 8) begin
                check_eq("t4_busy", busy, 1);
                check_eq("t4_in_ready", in_ready, 0);
                check_eq("t4_hold", hold_signals, 0);
                check_eq("t4_alarm", alarm, 1);
                check_eq("t4_err_count", err_count, 1);
                check_eq("t4_err_count_c", err_count_c, 1);
            end
            if (k == 9) begin
                check_eq("t4_resume_busy", busy, 0);
                check_eq("t4_resume_in_ready", in_ready, 1);
            end
            adv();
        end
        alarm_clr = 1'b1;
        adv();
        alarm_clr = 1'b0;
        @(negedge clk);
        check_eq("t4_clr_alarm", alarm, 0);
        check_eq("t4_clr_keeps_count", err_count, 1);
        adv();

        // Error on an empty layer is ignored
        for (int k = 0; k < 5; k++) begin
            in_valid = (k == 0); in_data = 8'h60;
            error_signals = (k == 1) ? 4'b1000 : 4'b0000;
            @(negedge clk);
            if (k == 1) check_eq("t5_in_ready", in_ready, 1);
            if (k == 2) begin
                check_eq("t5_alarm", alarm, 0);
                check_eq("t5_busy", busy, 0);
                check_eq("t5_err_count", err_count, 1);
            end
            if (k == 4) begin
                check_eq("t5_out_valid", out_valid, 1);
                check_eq("t5_out_data", out_data, 8'h64);
            end
            adv();
        end

        // Repeated errors: saturation of the narrow counter, set beats clear
        for (int n = 0; n < 5; n++) begin
            in_valid = 1'b1; in_data = 8'h70;
            adv();
            in_valid = 1'b0; error_signals = 4'b0001; alarm_clr = (n == 4);
            @(negedge clk);
            check_eq("t6_err_out_valid", out_valid, 0);
            adv();
            error_signals = 4'b0000; alarm_clr = 1'b0;
            @(negedge clk);
            check_eq("t6_busy", busy, 1);
            check_eq("t6_alarm", alarm, 1);
            check_eq("t6_alarm_c", alarm_c, 1);
            check_eq("t6_err_count", err_count, t6_cnt[n]);
            check_eq("t6_err_count_c", err_count_c, t6_cntc[n]);
            repeat (4) adv();
            @(negedge clk);
            check_eq("t6_scrub_done", busy, 0);
            adv();
        end
        alarm_clr = 1'b1;
        adv();
        alarm_clr = 1'b0;
        @(negedge clk);
        check_eq("t6_clr_alarm", alarm, 0);
        check_eq("t6_clr_alarm_c", alarm_c, 0);
        check_eq("t6_count_kept", err_count, 6);
        check_eq("t6_count_kept_c", err_count_c, 3);
        adv();

        // Reset in the middle of a scrub
        in_valid = 1'b1; in_data = 8'h70;
        adv();
        in_valid = 1'b0; error_signals = 4'b0001;
        adv();
        error_signals = 4'b0000;
        adv();
        @(negedge clk);
        check_eq("t7_busy_before_rst", busy, 1);
        #1 rst = 1'b1;
        #1;
        check_eq("t7_rst_busy", busy, 0);
        check_eq("t7_rst_in_ready", in_ready, 1);
        check_eq("t7_rst_hold", hold_signals, 0);
        check_eq("t7_rst_out_valid", out_valid, 0);
        check_eq("t7_rst_alarm", alarm, 0);
        check_eq("t7_rst_err_count", err_count, 0);
        check_eq("t7_rst_err_count_c", err_count_c, 0);
        adv();
        rst = 1'b0;
        @(negedge clk);
        check_eq("t7_after_in_ready", in_ready, 1);
        check_eq("t7_after_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
